// File: rtl/cache_2way.sv
// Two-way set-associative line store with per-set LRU, combinational tag match
// and registered lookup outputs (one-cycle latency).
module cache_2way #(
    parameter  int ADDR_W = 11,
    parameter  int IDX_W  = 6,
    parameter  int LINE_W = 64,
    localparam int TAG_W  = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wdirty,
    input  logic              we,
    input  logic              re,
    output logic [LINE_W-1:0] rd_data,
    output logic [TAG_W-1:0]  tag_out,
    output logic              hit,
    output logic              dirty,
    output logic              way
);

    localparam int SETS = 1 << IDX_W;

    logic [1:0]        valid_q [SETS];
    logic [1:0]        dirty_q [SETS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [LINE_W-1:0] data_mem [2][SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_in;
    logic [1:0]        match;
    logic              sel_way;
    logic              lookup_hit;

    assign idx        = addr[IDX_W-1:0];
    assign tag_in     = addr[ADDR_W-1:IDX_W];
    assign match[0]   = valid_q[idx][0] && (tag_mem[0][idx] == tag_in);
    assign match[1]   = valid_q[idx][1] && (tag_mem[1][idx] == tag_in);
    assign lookup_hit = |match;

    // Way 0 wins a duplicate match; otherwise fill invalid ways before evicting LRU.
    always_comb begin
        sel_way = lru_q[idx];
        if (match[0])
            sel_way = 1'b0;
        else if (match[1])
            sel_way = 1'b1;
        else if (!valid_q[idx][0])
            sel_way = 1'b0;
        else if (!valid_q[idx][1])
            sel_way = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 2'b00;
                dirty_q[s] <= 2'b00;
            end
            lru_q   <= '0;
            hit     <= 1'b0;
            dirty   <= 1'b0;
            way     <= 1'b0;
            tag_out <= '0;
            rd_data <= '0;
        end else if (we) begin
            valid_q[idx][sel_way] <= 1'b1;
            dirty_q[idx][sel_way] <= wdirty;
            lru_q[idx]            <= ~sel_way;
        end else if (re) begin
            hit     <= lookup_hit;
            way     <= sel_way;
            rd_data <= data_mem[sel_way][idx];
            tag_out <= tag_mem[sel_way][idx];
            dirty   <= valid_q[idx][sel_way] & dirty_q[idx][sel_way];
            if (lookup_hit)
                lru_q[idx] <= ~sel_way;
        end
    end

    // Payload arrays carry no reset; a cleared valid bit hides whatever they hold.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[sel_way][idx]  <= tag_in;
            data_mem[sel_way][idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cache_2way.sv
// Bench for cache_2way: directed scenarios plus randomized traffic against a
// behavioural set/way model.
module tb_cache_2way;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] addr;
    logic [63:0] wr_data;
    logic        wdirty;
    logic        we;
    logic        re;
    logic [63:0] rd_data;
    logic [4:0]  tag_out;
    logic        hit;
    logic        dirty;
    logic        way;

    int tests = 0;
    int fails = 0;

    cache_2way #(.ADDR_W(11), .IDX_W(6), .LINE_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .wdirty(wdirty),
        .we(we), .re(re), .rd_data(rd_data), .tag_out(tag_out), .hit(hit),
        .dirty(dirty), .way(way)
    );

    always #5 clk = ~clk;

    // Reference model: contents of each set as a pair of line slots plus LRU.
    bit        m_valid [2][64];
    bit        m_dirty [2][64];
    bit [4:0]  m_tag   [2][64];
    bit [63:0] m_data  [2][64];
    bit        m_lru   [64];

    bit        e_hit, e_way, e_dirty, e_known;
    bit [4:0]  e_tag;
    bit [63:0] e_data;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 0; m_valid[1][s] = 0;
            m_dirty[0][s] = 0; m_dirty[1][s] = 0;
            m_lru[s] = 0;
        end
        e_hit = 0; e_way = 0; e_dirty = 0; e_tag = 0; e_data = 0; e_known = 1;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, "_hit"}, hit, e_hit);
        chk({ctx, "_way"}, way, e_way);
        chk({ctx, "_dirty"}, dirty, e_dirty);
        if (e_known) begin
            chk({ctx, "_rd_data"}, rd_data, e_data);
            chk({ctx, "_tag_out"}, tag_out, e_tag);
        end
    endtask

    // One clock: drive, let the model step, sample one time unit after the edge.
    task automatic cycle(input bit r, input bit w, input logic [10:0] a,
                         input logic [63:0] d, input bit wd, input string ctx);
        int s;
        bit [4:0] t;
        int pick;
        bit found;
        re = r; we = w; addr = a; wr_data = d; wdirty = wd;
        s = int'(a[5:0]);
        t = a[10:6];
        found = 0;
        pick = 0;
        for (int k = 0; k < 2; k++)
            if (!found && m_valid[k][s] && m_tag[k][s] == t) begin
                found = 1; pick = k;
            end
        if (!found) begin
            if (!m_valid[0][s])      pick = 0;
            else if (!m_valid[1][s]) pick = 1;
            else                     pick = int'(m_lru[s]);
        end
        if (w) begin
            m_valid[pick][s] = 1;
            m_dirty[pick][s] = wd;
            m_tag[pick][s]   = t;
            m_data[pick][s]  = d;
            m_lru[s]         = (pick == 0);
        end else if (r) begin
            e_hit   = found;
            e_way   = (pick == 1);
            e_dirty = m_valid[pick][s] && m_dirty[pick][s];
            e_known = m_valid[pick][s];
            e_tag   = m_tag[pick][s];
            e_data  = m_data[pick][s];
            if (found) m_lru[s] = (pick == 0);
        end
        @(posedge clk);
        #1;
        re = 0; we = 0;
        check_outputs(ctx);
    endtask

    initial begin
        rst_n = 0; addr = '0; wr_data = '0; wdirty = 0; we = 0; re = 0;
        model_reset();
        #1;
        check_outputs("reset");
        #12 rst_n = 1;

        cycle(1, 0, 11'h005, 64'h0, 0, "cold");
        chk("cold_hit_const", hit, 0);
        chk("cold_way_const", way, 0);

        cycle(0, 1, 11'h045, 64'h1111_2222_3333_4444, 0, "fill0");
        cycle(1, 0, 11'h045, 64'h0, 0, "rd045");
        chk("rd045_data_const", rd_data, 64'h1111_2222_3333_4444);
        chk("rd045_way_const", way, 0);

        cycle(0, 1, 11'h085, 64'hAAAA, 1, "fill1");
        cycle(1, 0, 11'h085, 64'h0, 0, "rd085");
        chk("rd085_way_const", way, 1);
        chk("rd085_dirty_const", dirty, 1);
        cycle(1, 0, 11'h045, 64'h0, 0, "rd045b");
        chk("rd045b_hit_const", hit, 1);

        cycle(1, 0, 11'h0C5, 64'h0, 0, "evict");
        chk("evict_hit_const", hit, 0);
        chk("evict_way_const", way, 1);
        chk("evict_tag_const", tag_out, 5'h02);
        chk("evict_dirty_const", dirty, 1);
        cycle(0, 1, 11'h0C5, 64'h5555_6666, 0, "fillC5");
        cycle(1, 0, 11'h085, 64'h0, 0, "rd085m");
        chk("rd085m_hit_const", hit, 0);
        cycle(1, 0, 11'h045, 64'h0, 0, "rd045c");
        chk("rd045c_hit_const", hit, 1);

        cycle(1, 1, 11'h10A, 64'hDEAD_BEEF, 1, "rewe");
        chk("rewe_hold_data", rd_data, 64'h1111_2222_3333_4444);
        cycle(1, 0, 11'h10A, 64'h0, 0, "rewe_rd");
        chk("rewe_rd_hit_const", hit, 1);

        for (int i = 0; i < 400; i++) begin
            int op;
            logic [10:0] a;
            op = int'($urandom_range(0, 9));
            a  = {3'b000, 2'($urandom_range(0, 3)), 4'b0000, 2'($urandom_range(0, 3))};
            cycle(op < 5 || op == 8, op >= 5 && op <= 8, a,
                  {$urandom, $urandom}, 1'($urandom), "rand");
        end

        #2 rst_n = 0;
        #1;
        chk("midrst_hit", hit, 0);
        chk("midrst_dirty", dirty, 0);
        chk("midrst_way", way, 0);
        chk("midrst_tag", tag_out, 0);
        chk("midrst_data", rd_data, 0);
        we = 1; addr = 11'h200; wr_data = 64'h77; wdirty = 1;
        @(posedge clk);
        #3 we = 0; rst_n = 1;
        model_reset();
        cycle(1, 0, 11'h200, 64'h0, 0, "lostwr");
        chk("lostwr_hit_const", hit, 0);
        for (int i = 0; i < 16; i++) begin
            logic [10:0] a;
            a = {3'b000, 2'(i / 4), 4'b0000, 2'(i % 4)};
            cycle(1, 0, a, 64'h0, 0, "postrst");
            chk("postrst_hit_const", hit, 0);
        end
        cycle(1, 0, 11'h045, 64'h0, 0, "postrst045");
        chk("postrst045_hit_const", hit, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
